peripheral_tl_burst_gen: RTL and testbench
==========================================

// Module: peripheral_tl_burst_gen
// PURPOSE
//  Parametrised burst address generator for the TileLink/AHB-style peripheral bus. Accepts one burst
//  descriptor (start address, size, burst code, length, prot, write) over a valid/ready handshake.
//  Emits one address beat per downstream handshake, covering SINGLE, INCR, INCRx and WRAPx.
//  Sits between a bus master front-end and the slave decoder.
// PARAMETERS
//  ADDR_W   32  address width in bits
//  DATA_W   32  data bus width in bits (32/64/128); sizes wider than the bus are rejected
//  LEN_W    8   INCR length field width; an INCR burst has req_len+1 beats (1..2^LEN_W)
// PORTS
//  HCLK        in   1       clock
//  HRESETn     in   1       asynchronous active-low reset
//  req_valid   in   1       descriptor valid
//  req_ready   out  1       generator idle, can accept a descriptor
//  req_addr    in   ADDR_W  start address
//  req_size    in   3       size code (BYTE..QWORD)
//  req_burst   in   3       burst code (SINGLE..INCR16)
//  req_len     in   LEN_W   beat count minus 1; used only for INCR
//  req_prot    in   3       protection code, passed through
//  req_write   in   1       1 = write burst
//  req_err     out  1       one-cycle pulse: the accepted descriptor was rejected
//  beat_valid  out  1       beat address valid
//  beat_ready  in   1       downstream accepts the beat
//  beat_addr   out  ADDR_W  current beat address
//  beat_size   out  3       latched size
//  beat_prot   out  3       latched prot
//  beat_write  out  1       latched write
//  beat_idx    out  LEN_W   beat index, 0-based
//  beat_last   out  1       current beat is the final beat
//  busy        out  1       burst in progress
// BEHAVIOUR
//  - Reset (async, HRESETn=0): state=IDLE; every output is 0 except req_ready=1. The bus is all-zero.
//  - FSM has three states: IDLE, BURST, ERR.
//  - IDLE: req_ready=1. On req_valid&&req_ready, latch the descriptor.
//      Valid descriptor: go to BURST. beat_valid=1 on the next cycle (1-cycle latency).
//      Invalid descriptor: go to ERR.
//  - Invalid descriptor, any one of:
//      (a) size > log2(DATA_W/8);
//      (b) req_addr not aligned to 1<<size;
//      (c) KB-boundary violation, only when the optional macro is defined.
//  - ERR: req_err=1 for exactly one cycle; beat_valid stays 0; return to IDLE.
//  - BURST:
//      beat_valid=1. Outputs are held stable while beat_ready=0.
//      On beat_valid&&beat_ready:
//        beat_idx increments;
//        beat_addr advances to the next address;
//        if beat_last was 1, go to IDLE with beat_valid=0.
//      Back-to-back bursts always have at least one idle cycle (req_ready=0 while busy).
//  - Beat count per burst code:
//      SINGLE 1; WRAP4/INCR4 4; WRAP8/INCR8 8; WRAP16/INCR16 16; INCR req_len+1.
//      beat_last = (beat_idx == beats-1).
//  - Next address, with inc=1<<size:
//      INCR/INCRx: addr+inc, modulo 2^ADDR_W (wraps silently).
//      WRAPx: mask = beats*inc-1; next = (addr & ~mask) | ((addr+inc) & mask).
//  - Undefined burst/size codes (X) are treated as invalid (ERR).
//  - busy = (state != IDLE).
// CONFIGURATION
//  PERIPHERAL_TL_KB_BOUNDARY_EN defined:
//    An INCR/INCRx burst whose last beat address lies in a different 1KB region than req_addr
//    is invalid (ERR, no beats). WRAPx is never rejected by this rule.
//  PERIPHERAL_TL_KB_BOUNDARY_EN undefined:
//    No boundary check; addresses increment across 1KB regions.
// STRUCTURE
//  peripheral_tl_pkg: the existing size/burst/prot codes, plus:
//    - typedef struct tl_burst_req_t {addr, size, burst, len, prot, write};
//    - function burst_beats(burst, len);
//    - localparam KB_MASK.
//  Sub-module peripheral_tl_burst_addr_next: combinational next-address unit
//    (inputs addr, size, burst; output next_addr). All sequential logic and the FSM stay in the top.
// TESTING (DATA_W=32 unless noted)
//  1. WRAP4, WORD, addr 0x38, beat_ready=1 -> beats 0x38,0x3C,0x30,0x34; beat_last on the 4th beat; then idle.
//  2. INCR, HWORD, addr 0x100, len=2 -> 0x100,0x102,0x104; beat_idx 0,1,2; beat_last on 0x104.
//  3. INCR4, WORD, addr 0x0, beat_ready=0 for 3 cycles at beat 1 -> beat_addr=0x4 and beat_idx=1 held, then resumes.
//  4. QWORD at 0x0, or WORD at 0x2 -> req_err pulse of 1 cycle; beat_valid never 1; req_ready=1 two cycles later.
//  5. INCR8, WORD, addr 0x3F0 -> with the macro: req_err, no beats. Without it: 0x3F0..0x40C, 8 beats.
//  6. HRESETn low during beat 2 of INCR16 -> outputs zero immediately; after release, a SINGLE at 0x80 gives one beat, beat_last=1.

Source files
------------

// File: rtl/peripheral_tl_pkg.sv
// peripheral_tl_pkg: bus size/burst/prot codes, burst descriptor type and beat-count helpers.
package peripheral_tl_pkg;
  localparam int unsigned TL_ADDR_W = 32;
  localparam int unsigned TL_LEN_W = 8;
  localparam logic [31:0] KB_MASK = 32'h0000_03FF;
  typedef enum logic [2:0] {
    SIZE_BYTE, SIZE_HWORD, SIZE_WORD, SIZE_DWORD, SIZE_QWORD, SIZE_RSVD5, SIZE_RSVD6, SIZE_RSVD7
  } tl_size_e;
  typedef enum logic [2:0] {
    BURST_SINGLE, BURST_INCR, BURST_WRAP4, BURST_INCR4, BURST_WRAP8, BURST_INCR8, BURST_WRAP16, BURST_INCR16
  } tl_burst_e;
  typedef logic [2:0] tl_prot_t;
  localparam tl_prot_t PROT_PRIV = 3'b001;
  localparam tl_prot_t PROT_NONSEC = 3'b010;
  localparam tl_prot_t PROT_INSTR = 3'b100;
  typedef logic [TL_LEN_W:0] tl_beats_t;
  typedef struct packed {
    logic [TL_ADDR_W-1:0] addr;
    tl_size_e size;
    tl_burst_e burst;
    logic [TL_LEN_W-1:0] len;
    tl_prot_t prot;
    logic write;
  } tl_burst_req_t;
  function automatic logic is_wrap(tl_burst_e burst);
    return burst inside {BURST_WRAP4, BURST_WRAP8, BURST_WRAP16};
  endfunction
  function automatic tl_beats_t burst_beats(tl_burst_e burst, logic [TL_LEN_W-1:0] len);
    return burst == BURST_INCR ? tl_beats_t'(len) + 1'b1 :
           burst inside {BURST_WRAP4, BURST_INCR4} ? tl_beats_t'(4) :
           burst inside {BURST_WRAP8, BURST_INCR8} ? tl_beats_t'(8) :
           burst inside {BURST_WRAP16, BURST_INCR16} ? tl_beats_t'(16) : tl_beats_t'(1);
  endfunction
endpackage

// File: rtl/peripheral_tl_burst_addr_next.sv
// peripheral_tl_burst_addr_next: combinational next beat address for incrementing and wrapping bursts.
module peripheral_tl_burst_addr_next
  import peripheral_tl_pkg::*;
#(
  parameter int unsigned ADDR_W = TL_ADDR_W
) (
  input  logic [ADDR_W-1:0] addr_i,
  input  tl_size_e          size_i,
  input  tl_burst_e         burst_i,
  output logic [ADDR_W-1:0] next_addr_o
);
  logic [ADDR_W-1:0] inc, sum, mask;
  always_comb begin
    inc = ADDR_W'(1) << size_i;
    sum = addr_i + inc;
    mask = (ADDR_W'(burst_beats(burst_i, '0)) << size_i) - ADDR_W'(1);
    next_addr_o = is_wrap(burst_i) ? (addr_i & ~mask) | (sum & mask) : sum;
  end
endmodule

// File: rtl/peripheral_tl_burst_gen.sv
// peripheral_tl_burst_gen: accepts one burst descriptor and emits one address beat per downstream handshake.
// Optional PERIPHERAL_TL_KB_BOUNDARY_EN rejects incrementing bursts that cross a 1KB region.
module peripheral_tl_burst_gen
  import peripheral_tl_pkg::*;
#(
  parameter int unsigned ADDR_W = TL_ADDR_W,
  parameter int unsigned DATA_W = 32,
  parameter int unsigned LEN_W  = TL_LEN_W
) (
  input  logic              HCLK,
  input  logic              HRESETn,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [2:0]        req_size,
  input  logic [2:0]        req_burst,
  input  logic [LEN_W-1:0]  req_len,
  input  logic [2:0]        req_prot,
  input  logic              req_write,
  output logic              req_err,
  output logic              beat_valid,
  input  logic              beat_ready,
  output logic [ADDR_W-1:0] beat_addr,
  output logic [2:0]        beat_size,
  output logic [2:0]        beat_prot,
  output logic              beat_write,
  output logic [LEN_W-1:0]  beat_idx,
  output logic              beat_last,
  output logic              busy
);
  localparam int unsigned MAX_SIZE = $clog2(DATA_W / 8);
  typedef enum logic [1:0] {IDLE, BURST, ERR} state_e;
  state_e state_q, state_d;
  tl_burst_req_t desc_q, desc_d;
  logic [LEN_W-1:0] idx_q, idx_d;
  logic [ADDR_W-1:0] next_addr, align_mask;
  logic size_bad, align_bad, kb_bad, req_bad;
  tl_beats_t beats;
  peripheral_tl_burst_addr_next #(.ADDR_W(ADDR_W)) u_addr_next (
    .addr_i      (ADDR_W'(desc_q.addr)),
    .size_i      (desc_q.size),
    .burst_i     (desc_q.burst),
    .next_addr_o (next_addr)
  );
  always_comb begin
    align_mask = ADDR_W'((8'd1 << req_size) - 8'd1);
    size_bad = req_size > 3'(MAX_SIZE);
    align_bad = |(req_addr & align_mask);
  end
`ifdef PERIPHERAL_TL_KB_BOUNDARY_EN
  logic [ADDR_W-1:0] last_addr;
  // Wrapping bursts stay inside their own aligned window, so only incrementing ones can cross.
  assign last_addr = req_addr + (ADDR_W'(burst_beats(tl_burst_e'(req_burst), req_len) - 1'b1) << req_size);
  assign kb_bad = !is_wrap(tl_burst_e'(req_burst)) && |((last_addr ^ req_addr) & ~ADDR_W'(KB_MASK));
`else
  assign kb_bad = 1'b0;
`endif
  assign req_bad = size_bad | align_bad | kb_bad | $isunknown({req_size, req_burst});
  assign beats = burst_beats(desc_q.burst, desc_q.len);
  always_comb begin
    state_d = state_q;
    desc_d = desc_q;
    idx_d = idx_q;
    unique case (state_q)
      IDLE: if (req_valid) begin
        desc_d = '{addr: TL_ADDR_W'(req_addr), size: tl_size_e'(req_size), burst: tl_burst_e'(req_burst),
                   len: req_len, prot: req_prot, write: req_write};
        idx_d = '0;
        state_d = req_bad ? ERR : BURST;
      end
      BURST: if (beat_ready) begin
        desc_d.addr = TL_ADDR_W'(next_addr);
        idx_d = idx_q + 1'b1;
        state_d = beat_last ? IDLE : BURST;
      end
      ERR: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      state_q <= IDLE;
      desc_q <= '0;
      idx_q <= '0;
    end else begin
      state_q <= state_d;
      desc_q <= desc_d;
      idx_q <= idx_d;
    end
  end
  assign req_ready = state_q == IDLE;
  assign req_err = state_q == ERR;
  assign beat_valid = state_q == BURST;
  assign busy = state_q != IDLE;
  assign beat_addr = ADDR_W'(desc_q.addr);
  assign beat_size = desc_q.size;
  assign beat_prot = desc_q.prot;
  assign beat_write = desc_q.write;
  assign beat_idx = idx_q;
  assign beat_last = beat_valid && ({1'b0, idx_q} == beats - 1'b1);
endmodule

// File: tb/tb_peripheral_tl_burst_gen.sv
// tb_peripheral_tl_burst_gen: directed self-checking bench for the burst address generator.
module tb_peripheral_tl_burst_gen;
  logic HCLK = 1'b0, HRESETn = 1'b0;
  logic req_valid = 1'b0, req_ready, req_write = 1'b0, req_err;
  logic [31:0] req_addr = '0, beat_addr;
  logic [2:0] req_size = '0, req_burst = '0, req_prot = '0, beat_size, beat_prot;
  logic [7:0] req_len = '0, beat_idx;
  logic beat_valid, beat_ready = 1'b0, beat_write, beat_last, busy;
  int tests = 0, fails = 0;

  always #5 HCLK = ~HCLK;

  peripheral_tl_burst_gen dut (
    .HCLK(HCLK), .HRESETn(HRESETn), .req_valid(req_valid), .req_ready(req_ready),
    .req_addr(req_addr), .req_size(req_size), .req_burst(req_burst), .req_len(req_len),
    .req_prot(req_prot), .req_write(req_write), .req_err(req_err), .beat_valid(beat_valid),
    .beat_ready(beat_ready), .beat_addr(beat_addr), .beat_size(beat_size), .beat_prot(beat_prot),
    .beat_write(beat_write), .beat_idx(beat_idx), .beat_last(beat_last), .busy(busy)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge HCLK);
    #1;
  endtask

  task automatic send(input logic [31:0] a, input logic [2:0] s, input logic [2:0] b, input logic [7:0] l);
    req_addr = a; req_size = s; req_burst = b; req_len = l; req_valid = 1'b1;
    tick();
    req_valid = 1'b0;
  endtask

  task automatic beat(input string tag, input logic [31:0] a, input int i, input logic last);
    chk({tag, " valid"}, 32'(beat_valid), 32'd1);
    chk({tag, " addr"}, beat_addr, a);
    chk({tag, " idx"}, 32'(beat_idx), 32'(i));
    chk({tag, " last"}, 32'(beat_last), 32'(last));
  endtask

  task automatic idle(input string tag);
    chk({tag, " idle valid"}, 32'(beat_valid), 32'd0);
    chk({tag, " idle busy"}, 32'(busy), 32'd0);
    chk({tag, " idle ready"}, 32'(req_ready), 32'd1);
  endtask

  initial begin
    logic [31:0] wrap_exp [4];
    wrap_exp = '{32'h38, 32'h3C, 32'h30, 32'h34};
    tick(); tick();
    chk("rst ready", 32'(req_ready), 32'd1);
    chk("rst valid", 32'(beat_valid), 32'd0);
    chk("rst err", 32'(req_err), 32'd0);
    chk("rst busy", 32'(busy), 32'd0);
    chk("rst addr", beat_addr, 32'd0);
    chk("rst idx", 32'(beat_idx), 32'd0);
    chk("rst last", 32'(beat_last), 32'd0);
    HRESETn = 1'b1;
    tick();
    // WRAP4 word burst with pass-through attributes
    beat_ready = 1'b1; req_prot = 3'b101; req_write = 1'b1;
    send(32'h38, 3'd2, 3'd2, 8'd0);
    chk("wrap4 size", 32'(beat_size), 32'd2);
    chk("wrap4 prot", 32'(beat_prot), 32'd5);
    chk("wrap4 write", 32'(beat_write), 32'd1);
    chk("wrap4 ready busy", 32'(req_ready), 32'd0);
    for (int i = 0; i < 4; i++) begin
      beat("wrap4", wrap_exp[i], i, i == 3);
      tick();
    end
    idle("wrap4");
    req_prot = 3'b000; req_write = 1'b0;
    // INCR halfword, len=2
    send(32'h100, 3'd1, 3'd1, 8'd2);
    for (int i = 0; i < 3; i++) begin
      beat("incr", 32'h100 + 32'(2 * i), i, i == 2);
      tick();
    end
    idle("incr");
    // INCR4 with downstream stall at beat 1
    send(32'h0, 3'd2, 3'd3, 8'd0);
    beat("incr4 b0", 32'h0, 0, 1'b0);
    tick();
    beat_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      beat("incr4 stall", 32'h4, 1, 1'b0);
      tick();
    end
    beat_ready = 1'b1;
    beat("incr4 b1", 32'h4, 1, 1'b0);
    tick();
    beat("incr4 b2", 32'h8, 2, 1'b0);
    tick();
    beat("incr4 b3", 32'hC, 3, 1'b1);
    tick();
    idle("incr4");
    // oversize and misaligned descriptors
    send(32'h0, 3'd4, 3'd0, 8'd0);
    chk("qword err", 32'(req_err), 32'd1);
    chk("qword valid", 32'(beat_valid), 32'd0);
    chk("qword ready", 32'(req_ready), 32'd0);
    tick();
    chk("qword err end", 32'(req_err), 32'd0);
    idle("qword");
    send(32'h2, 3'd2, 3'd3, 8'd0);
    chk("misalign err", 32'(req_err), 32'd1);
    chk("misalign valid", 32'(beat_valid), 32'd0);
    tick();
    chk("misalign err end", 32'(req_err), 32'd0);
    idle("misalign");
    // INCR8 crossing the 1KB line at 0x400
    send(32'h3F0, 3'd2, 3'd5, 8'd0);
`ifdef PERIPHERAL_TL_KB_BOUNDARY_EN
    chk("kb err", 32'(req_err), 32'd1);
    chk("kb valid", 32'(beat_valid), 32'd0);
    tick();
    idle("kb");
`else
    for (int i = 0; i < 8; i++) begin
      beat("incr8", 32'h3F0 + 32'(4 * i), i, i == 7);
      tick();
    end
    idle("incr8");
`endif
    // reset mid-burst, then a SINGLE
    send(32'h200, 3'd2, 3'd7, 8'd0);
    tick(); tick();
    beat("incr16 b2", 32'h208, 2, 1'b0);
    HRESETn = 1'b0;
    #1;
    chk("arst valid", 32'(beat_valid), 32'd0);
    chk("arst addr", beat_addr, 32'd0);
    chk("arst idx", 32'(beat_idx), 32'd0);
    chk("arst busy", 32'(busy), 32'd0);
    chk("arst ready", 32'(req_ready), 32'd1);
    tick();
    HRESETn = 1'b1;
    send(32'h80, 3'd2, 3'd0, 8'd0);
    beat("single", 32'h80, 0, 1'b1);
    tick();
    idle("single");
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
